// File: rtl/au_bit_serial_adder_if.sv
// Operand/result handshake bundle for au_bit_serial_adder.
// The sub signal exists only when AU_BIT_SERIAL_ADDER_SUB_EN is defined.
interface au_bit_serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef AU_BIT_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;

    modport master (
        output in_valid, a, b, ci, out_ready,
`ifdef AU_BIT_SERIAL_ADDER_SUB_EN
               sub,
`endif
        input  in_ready, out_valid, s, co
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
`ifdef AU_BIT_SERIAL_ADDER_SUB_EN
               sub,
`endif
        output in_ready, out_valid, s, co
    );
endinterface

// File: rtl/au_bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus shift registers, LSB first, WIDTH cycles per sum.
// Optional AU_BIT_SERIAL_ADDER_SUB_EN adds a sub input selecting a - b.
module au_bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    au_bit_serial_adder_if.slave  bus
);
    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam int unsigned LAST = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             co_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH:0]   sum_cat;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Single full-adder cell; the new sum bit enters the sum register at the MSB.
    always_comb begin
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_cat   = {sum_bit, sum_sr};
    end

    // Subtraction is a + ~b + 1, so only the load path changes.
`ifdef AU_BIT_SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.ci;
        if (bus.sub) begin
            b_load     = ~bus.b;
            carry_load = 1'b1;
        end
    end
`else
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.ci;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr       <= bus.a;
                        b_sr       <= b_load;
                        carry      <= carry_load;
                        count      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_cat[WIDTH:1];
                    carry  <= carry_nxt;
                    count  <= count + CW'(1);
                    if (count == CW'(LAST)) begin
                        co_q        <= carry_nxt;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = sum_sr;
    assign bus.co        = co_q;
endmodule
